spi_slave_responder: RTL and testbench

SPI slave (responder) for the uart_spi design: the far end of the SPI master already in uart_spi_top. It oversamples an externally driven SCLK/CS_BAR/MOSI on the system clock and shifts received bytes out on a valid/ack interface. It shifts transmit bytes from a one-entry buffer onto MISO. The bus is SPI mode 0 (CPOL=0, CPHA=0), MSB first, and back-to-back frames are allowed within one CS_BAR assertion.

---
 rtl/spi_slave_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave_responder.sv | 157 +++++++++++++++
 tb/tb_spi_slave_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and default sizing for the SPI responder.
package spi_slave_pkg;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_o = level & ~prev_q;
  assign fall_o = ~level & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled SCLK/CS_BAR/MOSI, valid/ack receive port,
// one-entry transmit buffer shifted onto MISO MSB first.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_bar,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  frame_abort
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_sync;

  spi_state_e             state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0]  rx_shift_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q;
  logic [DATA_WIDTH-1:0]  tx_buf_q;
  logic                   buf_full_q;
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_valid_q;
  logic                   rx_overrun_q;
  logic                   tx_underrun_q;
  logic                   frame_abort_q;

  logic                   accept;
  logic                   load;
  logic                   last_bit;
  logic [DATA_WIDTH-1:0]  rx_word_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .din_i  (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs_bar resets high so leaving reset never fakes a select.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .din_i  (cs_bar),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];
  assign accept    = tx_valid & ~buf_full_q;
  assign last_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign rx_word_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};

  // A frame load happens on select, and on the falling edge that follows a completed frame.
  assign load = ((state_q == ST_IDLE) && cs_fall) ||
                ((state_q == ST_ACTIVE) && !cs_rise && sclk_fall && (bit_cnt_q == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      buf_full_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;

      if (rx_ack) rx_valid_q <= 1'b0;

      if (accept) begin
        tx_buf_q   <= tx_data;
        buf_full_q <= 1'b1;
      end

      if (load) begin
        if (buf_full_q) begin
          tx_shift_q <= tx_buf_q;
          buf_full_q <= 1'b0;
        end else begin
          tx_shift_q    <= '0;
          tx_underrun_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            if (bit_cnt_q != '0) frame_abort_q <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= rx_word_d;
              bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + 1'b1;
              if (last_bit) begin
                // Newest frame wins; an ack in the same cycle absorbs the old one.
                rx_data_q  <= rx_word_d;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !rx_ack) rx_overrun_q <= 1'b1;
              end
            end
            if (sclk_fall && (bit_cnt_q != '0)) begin
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso        = (state_q == ST_ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: table of single frames plus hand-built corner sequences.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_bar = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       frame_abort;

  int errors = 0;
  int checks = 0;
  int n_under = 0;
  int n_over = 0;
  int n_abort = 0;

  always #5 clk = ~clk;

  spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_bar      (cs_bar),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  always @(negedge clk) begin
    if (tx_underrun) n_under <= n_under + 1;
    if (rx_overrun)  n_over  <= n_over + 1;
    if (frame_abort) n_abort <= n_abort + 1;
  end

  typedef struct {
    logic [7:0] mosi_b;
    logic [7:0] tx_b;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs [4];

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    check("tx_ready_before_push", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
  endtask

  // Mode-0 master: mosi changes while sclk low, miso sampled at the rising edge.
  task automatic spi_xfer(input logic [7:0] tx_b, input int nbits, output logic [7:0] rx_b);
    rx_b = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx_b[i];
      wait_clks(4);
      rx_b[i] = miso;
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
    wait_clks(4);
  endtask

  task automatic cs_high();
    cs_bar = 1'b1;
    wait_clks(4);
  endtask

  initial begin
    logic [7:0] got;
    int u0, o0, a0;

    vecs[0] = '{mosi_b: 8'hA5, tx_b: 8'h3C, exp_rx: 8'hA5, exp_miso: 8'h3C};
    vecs[1] = '{mosi_b: 8'h00, tx_b: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[2] = '{mosi_b: 8'hFF, tx_b: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[3] = '{mosi_b: 8'h5A, tx_b: 8'h81, exp_rx: 8'h5A, exp_miso: 8'h81};

    wait_clks(3);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_pulses", {29'd0, rx_overrun, tx_underrun, frame_abort}, 32'd0);
    reset = 1'b0;
    wait_clks(2);

    // Single frames from the table
    for (int v = 0; v < 4; v++) begin
      o0 = n_over;
      a0 = n_abort;
      push_tx(vecs[v].tx_b);
      check("tx_ready_after_push", {31'd0, tx_ready}, 32'd0);
      cs_bar = 1'b0;
      spi_xfer(vecs[v].mosi_b, 8, got);
      check("vec_miso_byte", {24'd0, got}, {24'd0, vecs[v].exp_miso});
      check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_rx});
      check("vec_rx_valid", {31'd0, rx_valid}, 32'd1);
      check("vec_tx_ready", {31'd0, tx_ready}, 32'd1);
      cs_high();
      check("vec_idle_miso", {31'd0, miso}, 32'd0);
      check("vec_no_overrun_abort", n_over - o0 + n_abort - a0, 32'd0);
      ack_rx();
      check("vec_rx_valid_acked", {31'd0, rx_valid}, 32'd0);
    end

    // Back-to-back frames in one select, second byte queued during the first
    o0 = n_over;
    push_tx(8'h11);
    cs_bar = 1'b0;
    wait_clks(4);
    push_tx(8'h22);
    spi_xfer(8'hF0, 8, got);
    check("b2b_miso_0", {24'd0, got}, 32'h11);
    check("b2b_rx_0", {24'd0, rx_data}, 32'hF0);
    check("b2b_valid_0", {31'd0, rx_valid}, 32'd1);
    ack_rx();
    check("b2b_acked_0", {31'd0, rx_valid}, 32'd0);
    spi_xfer(8'h0F, 8, got);
    check("b2b_miso_1", {24'd0, got}, 32'h22);
    check("b2b_rx_1", {24'd0, rx_data}, 32'h0F);
    check("b2b_valid_1", {31'd0, rx_valid}, 32'd1);
    check("b2b_no_overrun", n_over - o0, 32'd0);
    cs_high();
    ack_rx();

    // Underrun: empty buffer at select; a byte queued mid-frame covers the trailing load
    u0 = n_under;
    cs_bar = 1'b0;
    wait_clks(4);
    check("underrun_at_select", n_under - u0, 32'd1);
    push_tx(8'hC3);
    spi_xfer(8'h77, 8, got);
    check("underrun_miso", {24'd0, got}, 32'h00);
    check("underrun_rx", {24'd0, rx_data}, 32'h77);
    check("underrun_once", n_under - u0, 32'd1);
    check("underrun_buf_consumed", {31'd0, tx_ready}, 32'd1);
    cs_high();
    ack_rx();

    // Overrun: two frames, no ack
    o0 = n_over;
    cs_bar = 1'b0;
    spi_xfer(8'h12, 8, got);
    check("overrun_none_first", n_over - o0, 32'd0);
    spi_xfer(8'h34, 8, got);
    check("overrun_pulse", n_over - o0, 32'd1);
    check("overrun_newest", {24'd0, rx_data}, 32'h34);
    check("overrun_valid", {31'd0, rx_valid}, 32'd1);
    cs_high();

    // Abort after 5 bits with an unread frame pending
    a0 = n_abort;
    cs_bar = 1'b0;
    spi_xfer(8'hE7, 5, got);
    cs_high();
    check("abort_pulse", n_abort - a0, 32'd1);
    check("abort_valid_kept", {31'd0, rx_valid}, 32'd1);
    check("abort_data_kept", {24'd0, rx_data}, 32'h34);
    ack_rx();
    push_tx(8'h99);
    cs_bar = 1'b0;
    spi_xfer(8'h6B, 8, got);
    check("post_abort_rx", {24'd0, rx_data}, 32'h6B);
    check("post_abort_miso", {24'd0, got}, 32'h99);
    cs_high();
    check("post_abort_no_abort", n_abort - a0, 32'd1);

    // Reset during bit 3 with a pending frame and a queued byte
    push_tx(8'h55);
    cs_bar = 1'b0;
    spi_xfer(8'hAA, 3, got);
    sclk = 1'b1;
    wait_clks(1);
    reset = 1'b1;
    wait_clks(2);
    check("rst_mid_miso", {31'd0, miso}, 32'd0);
    check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    sclk = 1'b0;
    cs_bar = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(4);
    push_tx(8'h4D);
    cs_bar = 1'b0;
    spi_xfer(8'hC6, 8, got);
    check("post_rst_rx", {24'd0, rx_data}, 32'hC6);
    check("post_rst_miso", {24'd0, got}, 32'h4D);
    check("post_rst_valid", {31'd0, rx_valid}, 32'd1);
    cs_high();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
